// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit-side arbiter and its helpers:
//   the arbiter state encoding, the byte width and the default watchdog limit.
//   No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

   // Width of one UART payload byte.
   localparam int BYTE_W = 8;

   // Default watchdog limit, in clk cycles, for a single byte in flight.
   localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      RELEASE   = 2'd3
   } arb_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches req upward starting at
//   rr_ptr, wrapping at NUM_REQ, and reports the first set bit.
//   Written without arbiter-specific state so a receive-side demux can
//   reuse it.
//
// Ports:
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   IDX_W    index with highest priority this round
//   winner  out  IDX_W    selected index (0 when valid is low)
//   valid   out  1        at least one request bit is set
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic [IDX_W-1:0] idx;

   // NOTE: every output of this block is assigned a default before the loop;
   // without that, paths where no bit is set would infer latches.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // Modulo keeps the search inside 0..NUM_REQ-1 even when NUM_REQ is
         // not a power of two.
         idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte producers. A requester
//   is chosen round-robin, its byte is latched and the transmitter is
//   launched with a one-cycle start pulse; the transmitter's completion pulse
//   is turned into a per-requester done pulse.
//
//   Optional feature (macro UART_TX_ARB_TIMEOUT_EN): a watchdog aborts a byte
//   whose completion does not arrive within TIMEOUT_CYCLES cycles. It drops
//   tx_en for one cycle and pulses err together with done[owner]. Without
//   the macro no counter exists, err is tied low and the arbiter waits
//   indefinitely for tx_done.
//
// Ports:
//   clk       in   1          system clock
//   rst       in   1          synchronous, active-high reset
//   req       in   NUM_REQ    request level per requester, held until gnt
//   req_data  in   NUM_REQ*8  requester i byte at [8i+7:8i]
//   gnt       out  NUM_REQ    one-hot pulse: byte accepted
//   done      out  NUM_REQ    one-hot pulse: byte transmitted or aborted
//   err       out  1          pulse when the watchdog aborts a byte
//   busy      out  1          high from grant until release
//   owner     out  IDX_W      index of the current or last owner
//   tx_en     out  1          transmitter enable (low = hold in reset)
//   tx_start  out  1          one-cycle launch pulse to the transmitter
//   tx_data   out  8          byte to the transmitter, stable until release
//   tx_busy   in   1          transmitter busy flag, not used for sequencing
//   tx_done   in   1          transmitter completion pulse
// ----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int IDX_W          = 2,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      err,
   output logic                      busy,
   output logic [IDX_W-1:0]          owner,
   output logic                      tx_en,
   output logic                      tx_start,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      tx_busy,
   input  logic                      tx_done
);

   arb_state_t       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;
   logic [IDX_W-1:0] next_ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // The requester just served drops to lowest priority next round.
   assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wd_cnt;
   logic             err_r;
   logic             unused_in;

   assign err       = err_r;
   // The transmitter's busy flag is observed only; sequencing relies on tx_done.
   assign unused_in = tx_busy;
`else
   logic unused_in;

   assign err       = 1'b0;
   assign unused_in = tx_busy ^ (TIMEOUT_CYCLES > 0);
`endif

   // NOTE: all state and registered outputs below use non-blocking
   // assignments so every register samples pre-edge values, independent of
   // statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         gnt      <= '0;
         done     <= '0;
         busy     <= 1'b0;
         tx_en    <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         err_r    <= 1'b0;
         wd_cnt   <= '0;
`endif
      end else begin
         // Pulse outputs default low; tx_en stays high except on an abort.
         gnt      <= '0;
         done     <= '0;
         tx_start <= 1'b0;
         tx_en    <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
         err_r    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               busy <= 1'b0;
               // Requests are sampled only here; bits rising in any other
               // state wait for the next IDLE cycle.
               if (pick_valid) begin
                  owner    <= pick_idx;
                  tx_data  <= req_data[pick_idx*BYTE_W +: BYTE_W];
                  gnt      <= NUM_REQ'(1) << pick_idx;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
                  state    <= LAUNCH;
               end
            end

            LAUNCH: begin
               // Any tx_done here belongs to an earlier frame and is ignored.
               state <= WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
               wd_cnt <= '0;
`endif
            end

            WAIT_DONE: begin
               if (tx_done) begin
                  done  <= NUM_REQ'(1) << owner;
                  state <= RELEASE;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Abort: pulse tx_en low to reset the transmitter and
                  // report the byte as finished with an error.
                  done  <= NUM_REQ'(1) << owner;
                  err_r <= 1'b1;
                  tx_en <= 1'b0;
                  state <= RELEASE;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
`endif
            end

            RELEASE: begin
               rr_ptr <= next_ptr;
               busy   <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule : uart_tx_arbiter
